// File: rtl/slice_reader_pkg.sv
// Shared constants for the three-slice activation-memory read initiator.
// Optional end-of-transfer flag is controlled by macro SLICE_READER_LAST_EN.
package slice_reader_pkg;
    localparam int SLICE_WORDS = 40;
    localparam int DW_DEFAULT  = 24;
    localparam int AW_DEFAULT  = 6;

    localparam logic [6:0] SLICE_BASE_0 = 7'd0;
    localparam logic [6:0] SLICE_BASE_1 = 7'd40;
    localparam logic [6:0] SLICE_BASE_2 = 7'd80;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t DRAIN = 2'd2;

    function automatic logic [6:0] slice_base(input logic [1:0] s);
        case (s)
            2'd1:    return SLICE_BASE_1;
            2'd2:    return SLICE_BASE_2;
            default: return SLICE_BASE_0;
        endcase
    endfunction

    function automatic logic [5:0] clamp_len(input logic [5:0] l);
        return (l > 6'(SLICE_WORDS)) ? 6'(SLICE_WORDS) : l;
    endfunction
endpackage

// File: rtl/slice_reader_fifo.sv
// Small synchronous FIFO with occupancy count; any depth, not just powers of two.
module sync_fifo_small #(
    parameter  int W     = 24,
    parameter  int DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          pop_ok, push_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
    assign empty   = (count == '0);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/slice_reader.sv
// Sequential slice reader: issues memory reads under credit control and streams words out.
// Define SLICE_READER_LAST_EN to add out_last marking the final word of a transfer.
module slice_reader
    import slice_reader_pkg::*;
#(
    parameter int DW     = DW_DEFAULT,
    parameter int AW     = AW_DEFAULT,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    slice,
    input  logic [5:0]    len,
    output logic [AW-1:0] rdaddr,
    output logic [1:0]    rdslc,
    input  logic [DW-1:0] rdout,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef SLICE_READER_LAST_EN
    output logic          out_last,
`endif
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int FD = RD_LAT + 2;
    localparam int CW = $clog2(FD + 1);
`ifdef SLICE_READER_LAST_EN
    localparam int FW = DW + 1;
`else
    localparam int FW = DW;
`endif

    state_t            state;
    logic [1:0]        slc_q;
    logic [5:0]        len_q, issued;
    logic              rd_vld_p0;
    logic [RD_LAT-1:0] tag_p;
    logic [CW-1:0]     fifo_cnt;
    logic [FW-1:0]     fifo_wdata, fifo_rdata;
    logic              fifo_empty, push, pop;
    logic              start_ok, issue, last_issue, final_hs;
    logic [3:0]        inflight, occ;
    logic [5:0]        len_c;

    assign len_c     = clamp_len(len);
    assign push      = tag_p[RD_LAT-1];
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign busy      = (state != IDLE);

    // Credit counts the word leaving this cycle as freed, otherwise a steady
    // stream would stall every other cycle.
    always_comb begin
        inflight = {3'b0, rd_vld_p0};
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + {3'b0, tag_p[i]};
        occ        = 4'(fifo_cnt) + inflight - {3'b0, pop};
        start_ok   = (state == IDLE) && start && (slice != 2'd3) && (len != 6'd0);
        issue      = start_ok || ((state == RUN) && (issued < len_q) && (occ < 4'(FD)));
        last_issue = (state == IDLE) ? (len_c == 6'd1) : (issued + 6'd1 == len_q);
        final_hs   = (state == DRAIN) && (inflight == 4'd0) && (fifo_cnt == CW'(1)) && pop;
    end

    always_ff @(posedge clk) begin
        if (start_ok) begin
            slc_q <= slice;
            len_q <= len_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            issued    <= '0;
            rdaddr    <= '0;
            rdslc     <= '0;
            rd_vld_p0 <= 1'b0;
            tag_p     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            rd_vld_p0 <= issue;
            // ---- read-latency tag pipeline ----
            tag_p[0]  <= rd_vld_p0;
            for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
            if (issue) begin
                rdaddr <= (state == IDLE) ? '0 : AW'(issued);
                rdslc  <= (state == IDLE) ? slice : slc_q;
                issued <= (state == IDLE) ? 6'd1 : issued + 6'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (slice == 2'd3)     err   <= 1'b1;
                        else if (len == 6'd0)  done  <= 1'b1;
                        else                   state <= last_issue ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (issue && last_issue) state <= DRAIN;
                end
                DRAIN: begin
                    if (final_hs) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SLICE_READER_LAST_EN
    logic              rd_last_p0;
    logic [RD_LAT-1:0] last_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_last_p0 <= 1'b0;
            last_p     <= '0;
        end else begin
            rd_last_p0 <= issue && last_issue;
            last_p[0]  <= rd_last_p0;
            for (int i = 1; i < RD_LAT; i++) last_p[i] <= last_p[i-1];
        end
    end

    assign fifo_wdata = {last_p[RD_LAT-1], rdout};
    assign out_last   = fifo_rdata[DW];
    assign out_data   = fifo_rdata[DW-1:0];
`else
    assign fifo_wdata = rdout;
    assign out_data   = fifo_rdata;
`endif

    sync_fifo_small #(.W(FW), .DEPTH(FD)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_cnt),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_slice_reader.sv
// Directed bench for slice_reader at RD_LAT=1 and RD_LAT=3 with a latency-matched memory model.
module tb_slice_reader;
    logic        clk = 1'b0;
    logic        rst_n, start1, start3, out_ready;
    logic [1:0]  slice;
    logic [5:0]  len;
    logic [5:0]  rdaddr1, rdaddr3;
    logic [1:0]  rdslc1, rdslc3;
    logic [23:0] rdout1, rdout3, od1, od3;
    logic        ov1, ov3, busy1, busy3, done1, done3, err1, err3;
`ifdef SLICE_READER_LAST_EN
    logic        ol1, ol3;
`endif
    int          mem_off;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    slice_reader #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .slice(slice), .len(len),
        .rdaddr(rdaddr1), .rdslc(rdslc1), .rdout(rdout1),
        .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
`ifdef SLICE_READER_LAST_EN
        .out_last(ol1),
`endif
        .busy(busy1), .done(done1), .err(err1)
    );

    slice_reader #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .slice(slice), .len(len),
        .rdaddr(rdaddr3), .rdslc(rdslc3), .rdout(rdout3),
        .out_data(od3), .out_valid(ov3), .out_ready(out_ready),
`ifdef SLICE_READER_LAST_EN
        .out_last(ol3),
`endif
        .busy(busy3), .done(done3), .err(err3)
    );

    // Memory model: word = (slice << 16) | (mem_off + addr), returned RD_LAT clocks after address.
    function automatic logic [23:0] mdata(input logic [7:0] sa);
        return (24'(sa[7:6]) << 16) | 24'(mem_off + int'(sa[5:0]));
    endfunction

    logic [7:0] mp1;
    logic [7:0] mp3 [0:2];
    always @(posedge clk) begin
        mp1    <= {rdslc1, rdaddr1};
        mp3[0] <= {rdslc3, rdaddr3};
        mp3[1] <= mp3[0];
        mp3[2] <= mp3[1];
    end
    assign rdout1 = mdata(mp1);
    assign rdout3 = mdata(mp3[2]);

    logic [23:0] got [0:63];
    int ngot, first_vld, done_cyc, done_cnt, slc_bad, stab_bad, last_bad;
    logic [5:0] addr_at20;
    logic       vld_at20;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // rmode: 0 ready high, 1 ready pattern 1,0,0,1..., 2 ready low for cycles 0..19
    task automatic xfer(input int lat, input logic [1:0] slc, input logic [5:0] ln,
                        input int rmode, input int abort_at, input int exp_n);
        logic        ov, bz, dn, pvld, phs;
        logic [23:0] od, pod;
        logic [1:0]  rs;
        logic [5:0]  ra;
`ifdef SLICE_READER_LAST_EN
        logic        ol;
`endif
        for (int i = 0; i < 64; i++) got[i] = 'x;
        ngot = 0; first_vld = -1; done_cyc = -1; done_cnt = 0;
        slc_bad = 0; stab_bad = 0; last_bad = 0;
        pvld = 1'b0; phs = 1'b0; pod = '0;
        slice = slc; len = ln;
        if (lat == 3) start3 = 1'b1; else start1 = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            out_ready = (rmode == 0) ? 1'b1 :
                        (rmode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : (cyc >= 20);
            ov = (lat == 3) ? ov3    : ov1;
            od = (lat == 3) ? od3    : od1;
            bz = (lat == 3) ? busy3  : busy1;
            dn = (lat == 3) ? done3  : done1;
            rs = (lat == 3) ? rdslc3 : rdslc1;
            ra = (lat == 3) ? rdaddr3 : rdaddr1;
`ifdef SLICE_READER_LAST_EN
            ol = (lat == 3) ? ol3 : ol1;
            if (ov && (ol !== (ngot == exp_n - 1))) last_bad++;
`endif
            if (ov && first_vld < 0) first_vld = cyc;
            if (pvld && !phs && (!ov || od !== pod)) stab_bad++;
            if (cyc >= 1 && bz && rs !== slc) slc_bad++;
            if (cyc == 20) begin addr_at20 = ra; vld_at20 = ov; end
            if (dn) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
            phs = ov && out_ready;
            pvld = ov; pod = od;
            if (phs && ngot < 64) begin got[ngot] = od; ngot++; end
            if (abort_at > 0 && ngot == abort_at) begin
                #2;
                rst_n = 1'b0;
                start1 = 1'b0; start3 = 1'b0;
                return;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            tick();
            if (cyc == 0) begin start1 = 1'b0; start3 = 1'b0; end
        end
    endtask

    initial begin
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; out_ready = 1'b0;
        slice = 2'd0; len = 6'd0; mem_off = 0;
        repeat (3) tick();
        chk("rst_rdaddr", 32'(rdaddr1), 0);
        chk("rst_rdslc", 32'(rdslc1), 0);
        chk("rst_valid", 32'(ov1), 0);
        chk("rst_data", 32'(od1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_done", 32'(done1), 0);
        chk("rst_err", 32'(err1), 0);
        rst_n = 1'b1;
        tick();

        // Full-rate slice 1 read
        mem_off = 1000;
        xfer(1, 2'd1, 6'd40, 0, 0, 40);
        chk("t1_count", 32'(ngot), 40);
        for (int i = 0; i < 40; i++) chk("t1_word", 32'(got[i]), 32'h10000 + 1000 + i);
        chk("t1_first_valid", 32'(first_vld), 3);
        chk("t1_done_cycle", 32'(done_cyc), 43);
        chk("t1_done_pulses", 32'(done_cnt), 1);
        chk("t1_rdslc", 32'(slc_bad), 0);
        chk("t1_last", 32'(last_bad), 0);

        // Toggling backpressure on slice 2
        mem_off = 0;
        xfer(1, 2'd2, 6'd5, 1, 0, 5);
        chk("t2_count", 32'(ngot), 5);
        for (int i = 0; i < 5; i++) chk("t2_word", 32'(got[i]), 32'h20000 + i);
        chk("t2_stable", 32'(stab_bad), 0);
        chk("t2_done_pulses", 32'(done_cnt), 1);
        chk("t2_last", 32'(last_bad), 0);

        // Ready held low: only three reads may be outstanding
        xfer(1, 2'd0, 6'd10, 2, 0, 10);
        chk("t3_addr_stalled", 32'(addr_at20), 2);
        chk("t3_valid_stalled", 32'(vld_at20), 1);
        chk("t3_count", 32'(ngot), 10);
        for (int i = 0; i < 10; i++) chk("t3_word", 32'(got[i]), i);
        chk("t3_stable", 32'(stab_bad), 0);
        chk("t3_done_pulses", 32'(done_cnt), 1);

        // Illegal slice, then zero length
        slice = 2'd3; len = 6'd8; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("t4_err_pulse", 32'(err1), 1);
        chk("t4_err_busy", 32'(busy1), 0);
        chk("t4_err_rdaddr", 32'(rdaddr1), 9);
        tick();
        chk("t4_err_clear", 32'(err1), 0);
        chk("t4_err_busy2", 32'(busy1), 0);
        slice = 2'd0; len = 6'd0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("t4_len0_done", 32'(done1), 1);
        chk("t4_len0_valid", 32'(ov1), 0);
        chk("t4_len0_busy", 32'(busy1), 0);
        tick();
        chk("t4_len0_done_clear", 32'(done1), 0);
        chk("t4_len0_valid2", 32'(ov1), 0);

        // Reset during a transfer, then a clamped full read
        xfer(1, 2'd1, 6'd63, 0, 17, 40);
        #1;
        chk("t5_abort_valid", 32'(ov1), 0);
        chk("t5_abort_data", 32'(od1), 0);
        chk("t5_abort_rdaddr", 32'(rdaddr1), 0);
        chk("t5_abort_rdslc", 32'(rdslc1), 0);
        chk("t5_abort_busy", 32'(busy1), 0);
        chk("t5_abort_done", 32'(done1), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        xfer(1, 2'd1, 6'd63, 0, 0, 40);
        chk("t5_clamp_count", 32'(ngot), 40);
        for (int i = 0; i < 40; i++) chk("t5_word", 32'(got[i]), 32'h10000 + i);
        chk("t5_done_cycle", 32'(done_cyc), 43);
        chk("t5_done_pulses", 32'(done_cnt), 1);

        // Three-clock memory latency
        mem_off = 500;
        xfer(3, 2'd0, 6'd40, 0, 0, 40);
        chk("t6_count", 32'(ngot), 40);
        for (int i = 0; i < 40; i++) chk("t6_word", 32'(got[i]), 500 + i);
        chk("t6_first_valid", 32'(first_vld), 5);
        chk("t6_done_cycle", 32'(done_cyc), 45);
        chk("t6_done_pulses", 32'(done_cnt), 1);
        chk("t6_last", 32'(last_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
